// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle between the switch front end and the serial adder controller.
// Optional iSub lane present only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             iStart;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             iCin;
`ifdef SERIAL_ADD_SUB_EN
  logic             iSub;
`endif
  logic             oBusy;
  logic             oDone;
  logic [WIDTH-1:0] oSum;
  logic             oCout;
  logic             oOvf;

`ifdef SERIAL_ADD_SUB_EN
  modport master (
    output iStart, iA, iB, iCin, iSub,
    input  oBusy, oDone, oSum, oCout, oOvf
  );
  modport slave (
    input  iStart, iA, iB, iCin, iSub,
    output oBusy, oDone, oSum, oCout, oOvf
  );
`else
  modport master (
    output iStart, iA, iB, iCin,
    input  oBusy, oDone, oSum, oCout, oOvf
  );
  modport slave (
    input  iStart, iA, iB, iCin,
    output oBusy, oDone, oSum, oCout, oOvf
  );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles from accept to oDone.
// Start is ignored while busy; SERIAL_ADD_SUB_EN adds the iSub (A-B) mode.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               iClk,
  input logic               iRst_n,
  serial_add_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             sub_sel;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH:0]   sum_cat;
  logic [WIDTH-1:0] sum_next;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = bus.iSub;
`else
  assign sub_sel = 1'b0;
`endif

  assign fa_s = a_sr[0] ^ b_sr[0] ^ carry;
  assign fa_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

  // New sum bit enters at the MSB; concatenation keeps WIDTH=1 legal.
  assign sum_cat  = {fa_s, sum_sr};
  assign sum_next = sum_cat[WIDTH:1];

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (bus.iStart) begin
            a_sr   <= bus.iA;
            b_sr   <= sub_sel ? ~bus.iB : bus.iB;
            carry  <= sub_sel ? 1'b1 : bus.iCin;
            sum_sr <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_next;
          carry  <= fa_c;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB at this point
            sum_q  <= sum_next;
            cout_q <= fa_c;
            ovf_q  <= carry ^ fa_c;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.oBusy = busy;
  assign bus.oDone = done;
  assign bus.oSum  = sum_q;
  assign bus.oCout = cout_q;
  assign bus.oOvf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): add, carry/overflow, ignored start,
// mid-run reset, back-to-back throughput; subtract vectors when SERIAL_ADD_SUB_EN is set.
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  always #5 iClk = ~iClk;

  // Drives one operation; returns observations, lat = -1 if oDone never came.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, output logic busy_e0, output int lat,
                        output logic [7:0] sum, output logic cout, output logic ovf,
                        output logic done_after);
    bit seen;
    bus.iStart = 1'b1;
    bus.iA     = a;
    bus.iB     = b;
    bus.iCin   = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus.iSub   = sub;
`endif
    @(posedge iClk); #1;
    busy_e0    = bus.oBusy;
    bus.iStart = 1'b0;
    lat  = 0;
    seen = 0;
    for (int k = 1; k <= 30 && !seen; k++) begin
      @(posedge iClk); #1;
      if (bus.oDone) begin
        seen = 1;
        lat  = k;
      end
    end
    if (!seen) lat = -1;
    sum  = bus.oSum;
    cout = bus.oCout;
    ovf  = bus.oOvf;
    @(posedge iClk); #1;
    done_after = bus.oDone;
  endtask

  task automatic test_reset;
    checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.oBusy); end
    checks++; if (bus.oDone !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.oDone); end
    checks++; if (bus.oSum !== 8'h00) begin errors++; $display("FAIL reset_sum got=%h exp=00", bus.oSum); end
    checks++; if (bus.oCout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", bus.oCout); end
    checks++; if (bus.oOvf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.oOvf); end
  endtask

  task automatic test_add_basic;
    logic b0, c, o, da; int lat; logic [7:0] s;
    run_op(8'h5A, 8'h33, 1'b0, 1'b0, b0, lat, s, c, o, da);
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL add_busy_e0 got=%b exp=1", b0); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL add_latency got=%0d exp=8", lat); end
    checks++; if (s !== 8'h8D) begin errors++; $display("FAIL add_sum got=%h exp=8d", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL add_cout got=%b exp=0", c); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL add_ovf got=%b exp=1", o); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL add_done_width got=%b exp=0", da); end
  endtask

  task automatic test_carry;
    logic b0, c, o, da; int lat; logic [7:0] s;
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, b0, lat, s, c, o, da);
    checks++; if (s !== 8'h00) begin errors++; $display("FAIL wrap_sum got=%h exp=00", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL wrap_cout got=%b exp=1", c); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL wrap_ovf got=%b exp=0", o); end
    run_op(8'h7F, 8'h00, 1'b1, 1'b0, b0, lat, s, c, o, da);
    checks++; if (s !== 8'h80) begin errors++; $display("FAIL cin_sum got=%h exp=80", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL cin_cout got=%b exp=0", c); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL cin_ovf got=%b exp=1", o); end
  endtask

  task automatic test_ignore_start;
    int pulses = 0;
    bus.iStart = 1'b1; bus.iA = 8'h01; bus.iB = 8'h02; bus.iCin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.iSub = 1'b0;
`endif
    @(posedge iClk); #1;
    bus.iStart = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        bus.iStart = 1'b1; bus.iA = 8'h44; bus.iB = 8'h44; bus.iCin = 1'b1;
      end
      if (k == 4) begin
        bus.iStart = 1'b0;
        checks++; if (bus.oSum !== 8'h80) begin errors++; $display("FAIL hold_sum_midrun got=%h exp=80", bus.oSum); end
      end
      @(posedge iClk); #1;
      if (bus.oDone) begin
        pulses++;
        checks++; if (bus.oSum !== 8'h03) begin errors++; $display("FAIL ignore_sum got=%h exp=03", bus.oSum); end
        checks++; if (k !== 8) begin errors++; $display("FAIL ignore_latency got=%0d exp=8", k); end
      end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_reset_midrun;
    logic b0, c, o, da; int lat; logic [7:0] s;
    bus.iStart = 1'b1; bus.iA = 8'h55; bus.iB = 8'h22; bus.iCin = 1'b0;
    @(posedge iClk); #1;
    bus.iStart = 1'b0;
    repeat (4) begin @(posedge iClk); #1; end
    iRst_n = 1'b0;
    #1;
    checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.oBusy); end
    checks++; if (bus.oSum !== 8'h00) begin errors++; $display("FAIL midrst_sum got=%h exp=00", bus.oSum); end
    checks++; if (bus.oDone !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", bus.oDone); end
    #3 iRst_n = 1'b1;
    @(posedge iClk); #1;
    checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL midrst_idle got=%b exp=0", bus.oBusy); end
    run_op(8'h01, 8'h01, 1'b0, 1'b0, b0, lat, s, c, o, da);
    checks++; if (s !== 8'h02) begin errors++; $display("FAIL post_rst_sum got=%h exp=02", s); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL post_rst_latency got=%0d exp=8", lat); end
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    int last = 0;
    bus.iStart = 1'b1; bus.iA = 8'h10; bus.iB = 8'h20; bus.iCin = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge iClk); #1;
      if (bus.oDone) begin
        pulses++;
        checks++; if (bus.oSum !== 8'h30) begin errors++; $display("FAIL b2b_sum got=%h exp=30", bus.oSum); end
        if (pulses > 1) begin
          checks++; if (k - last !== 9) begin errors++; $display("FAIL b2b_period got=%0d exp=9", k - last); end
        end
        last = k;
      end
    end
    bus.iStart = 1'b0;
    checks++; if (pulses !== 4) begin errors++; $display("FAIL b2b_pulses got=%0d exp=4", pulses); end
    repeat (12) @(posedge iClk);
    #1;
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    logic b0, c, o, da; int lat; logic [7:0] s;
    run_op(8'h10, 8'h01, 1'b0, 1'b1, b0, lat, s, c, o, da);
    checks++; if (s !== 8'h0F) begin errors++; $display("FAIL sub_sum got=%h exp=0f", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL sub_cout got=%b exp=1", c); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL sub_ovf got=%b exp=0", o); end
    run_op(8'h80, 8'h01, 1'b0, 1'b1, b0, lat, s, c, o, da);
    checks++; if (s !== 8'h7F) begin errors++; $display("FAIL subovf_sum got=%h exp=7f", s); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL subovf_ovf got=%b exp=1", o); end
    bus.iSub = 1'b0;
  endtask
`endif

  initial begin
    bus.iStart = 1'b0;
    bus.iA     = '0;
    bus.iB     = '0;
    bus.iCin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.iSub   = 1'b0;
`endif
    #23 iRst_n = 1'b1;
    @(posedge iClk); #1;
    test_reset();
    test_add_basic();
    test_carry();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that time-shares a single 1-bit full-adder cell across a WIDTH-bit addition, one bit per clock, LSB first. It accepts a start request with two operands and a carry-in, and sequences the full-adder cell through WIDTH steps using an internal carry register. It then presents the registered sum, carry-out and signed overflow with a one-cycle done pulse. It sits between the lab's operand/switch front end and the result display, replacing a WIDTH-bit ripple adder with one FA cell plus control.

## Interface
- WIDTH, default 8, operand/sum width in bits; legal range 1..32.
- iClk  input  1  system clock, rising edge active.
- iRst_n  input  1  asynchronous active-low reset.
- iStart  input  1  start request; sampled only when state is IDLE or DONE.
- iA  input  WIDTH  operand A; captured on the accepting edge.
- iB  input  WIDTH  operand B; captured on the accepting edge.
- iCin  input  1  carry-in; captured on the accepting edge.
- iSub  input  1  subtract select; present only with SERIAL_ADD_SUB_EN, captured on the accepting edge.
- oBusy  output  1  high while state is RUN.
- oDone  output  1  one-cycle pulse; high while state is DONE.
- oSum  output  WIDTH  result of the last completed operation.
- oCout  output  1  carry-out of the last completed operation.
- oOvf  output  1  signed overflow of the last completed operation: carry into MSB XOR carry-out.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE or DONE with iStart=1: load the A and B shift registers, set carry register to iCin, clear the bit counter, and go to RUN. Without iStart, IDLE stays IDLE and DONE goes to IDLE.
- RUN, each cycle:
  - Compute {c, s} = A[0] + B[0] + carry.
  - Shift s into the sum shift register from the MSB side, shift A and B right by 1, set carry to c, and increment the counter.
  - When counter = WIDTH-1 is processed, go to DONE.
- On the RUN→DONE edge:
  - oSum gets the final sum shift register value.
  - oCout gets the final c.
  - oOvf gets the carry into the MSB XOR the final c; for WIDTH=1 this is iCin XOR c.
- oSum, oCout and oOvf change only on the RUN→DONE edge. They hold between operations.
- iStart during RUN is ignored, with no queuing. Operands are only sampled on the accepting edge, so later changes to iA, iB or iCin do not affect the operation in flight.
- Counter width is clog2(WIDTH)+1. No wrap occurs, because the counter is cleared on every accept.
- Reset asserted at any time, including mid-RUN, does the following asynchronously:
  - State goes to IDLE.
  - All registers clear.
  - oBusy=0, oDone=0, oSum=0, oCout=0, oOvf=0.
  - The partial result is discarded.

## Timing
- Accepting edge E0 moves the state to RUN, so oBusy=1 from E0.
- Bit i is processed at edge E(i+1).
- At edge E(WIDTH): state goes to DONE, results update, oBusy=0 and oDone=1.
- Latency is WIDTH cycles from the accepting edge to oDone high. oDone stays high for exactly 1 cycle.
- Back-to-back operation: iStart=1 during the DONE cycle is accepted at that edge. Throughput is then one result per WIDTH+1 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - Adds the iSub port.
  - With iSub=1 at accept, B is loaded inverted and the carry register is forced to 1, ignoring iCin. The result is A−B.
  - oCout=1 means no borrow.
  - oOvf is the signed subtraction overflow.
- SERIAL_ADD_SUB_EN undefined:
  - The iSub port is absent.
  - The block performs addition only, with iCin honored.

## Test plan
- WIDTH=8, A=0x5A, B=0x33, Cin=0 → oDone 8 cycles after the accepting edge; oSum=0x8D, oCout=0, oOvf=1.
- A=0xFF, B=0x01, Cin=0 → oSum=0x00, oCout=1, oOvf=0. Then A=0x7F, B=0x00, Cin=1 → oSum=0x80, oCout=0, oOvf=1.
- Pulse iStart again 3 cycles into RUN with different operands → ignored; first result is unchanged and there is only a single oDone pulse.
- Assert iRst_n=0 at bit 4 of an operation → all outputs are 0 immediately and the state is IDLE. A fresh start of 0x01+0x01 then returns 0x02.
- iStart held high continuously with A=0x10, B=0x20 → oDone pulses every 9 cycles with oSum=0x30 each time.
- SERIAL_ADD_SUB_EN defined:
  - iSub=1, A=0x10, B=0x01 → oSum=0x0F, oCout=1, oOvf=0.
  - iSub=1, A=0x80, B=0x01 → oSum=0x7F, oOvf=1.
